// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for a 5-stage MIPS: load-use stall, branch flush,
// and front-end freeze while a multi-cycle MULT/DIV occupies EX; counts stall cycles.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_md_start,
  input  logic             ex_md_is_div,
  input  logic             branch_taken,
  output logic             PCwrite,
  output logic             IFIDwrite,
  output logic             IDEXwrite,
  output logic             IDEX_bubble,
  output logic             IFID_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 2);
  localparam logic [CW-1:0] DIV_INIT = CW'(DIV_LAT - 2);

  typedef enum logic {RUN, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          md_freeze, load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Latency is loaded as LAT-2: one cycle spent in RUN, one in the cnt==0 done cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: if (ex_md_start) begin
        state_nxt = BUSY;
        cnt_nxt   = ex_md_is_div ? DIV_INIT : MUL_INIT;
      end
      BUSY: if (cnt != '0) cnt_nxt = cnt - 1'b1;
            else           state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign md_freeze = ((state == RUN) && ex_md_start) || ((state == BUSY) && (cnt != '0));
  assign load_use  = ex_memread && (ex_rt != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  always_comb begin
    PCwrite     = 1'b1;
    IFIDwrite   = 1'b1;
    IDEXwrite   = 1'b1;
    IDEX_bubble = 1'b0;
    IFID_flush  = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    if (rst) begin
      PCwrite     = 1'b0;
      IFIDwrite   = 1'b0;
      IDEXwrite   = 1'b0;
      IDEX_bubble = 1'b1;
    end else begin
      md_busy = (state == BUSY);
      md_done = (state == BUSY) && (cnt == '0);
      if (md_freeze) begin
        PCwrite   = 1'b0;
        IFIDwrite = 1'b0;
        IDEXwrite = 1'b0;
      end else if (load_use) begin
        // Branch is ignored here: its operands are not ready until the stall clears.
        PCwrite     = 1'b0;
        IFIDwrite   = 1'b0;
        IDEX_bubble = 1'b1;
      end else begin
        IFID_flush = branch_taken;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         stall_cycles <= '0;
    else if (!PCwrite && (stall_cycles != {CNT_W{1'b1}})) stall_cycles <= stall_cycles + 1'b1;
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; CNT_W=5 so the DIV stall run reaches saturation.
module tb_hazard_stall_ctrl;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rs, id_uses_rt, ex_memread, ex_md_start, ex_md_is_div, branch_taken;
  logic             PCwrite, IFIDwrite, IDEXwrite, IDEX_bubble, IFID_flush, md_busy, md_done;
  logic [CNT_W-1:0] stall_cycles;

  int tests = 0;
  int fails = 0;
  int exp_sc = 0;

  hazard_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div), .branch_taken(branch_taken),
    .PCwrite(PCwrite), .IFIDwrite(IFIDwrite), .IDEXwrite(IDEXwrite),
    .IDEX_bubble(IDEX_bubble), .IFID_flush(IFID_flush), .md_busy(md_busy),
    .md_done(md_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; model the stall counter from the expected PCwrite of that cycle.
  task automatic tick(input bit stalled);
    @(posedge clk);
    #1;
    if (stalled && exp_sc < (1 << CNT_W) - 1) exp_sc++;
  endtask

  task automatic chk_ctl(input string tag, input logic pc, input logic idex,
                         input logic bub, input logic fl);
    chk({tag, ".PCwrite"},     {31'd0, PCwrite},     {31'd0, pc});
    chk({tag, ".IFIDwrite"},   {31'd0, IFIDwrite},   {31'd0, pc});
    chk({tag, ".IDEXwrite"},   {31'd0, IDEXwrite},   {31'd0, idex});
    chk({tag, ".IDEX_bubble"}, {31'd0, IDEX_bubble}, {31'd0, bub});
    chk({tag, ".IFID_flush"},  {31'd0, IFID_flush},  {31'd0, fl});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    exp_sc = 0;
    chk_ctl("rst", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst.md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst.md_done", {31'd0, md_done}, 32'd0);
    chk("rst.stall", {27'd0, stall_cycles}, 32'd0);
    tick(1'b0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_memread = 0; ex_md_start = 0; ex_md_is_div = 0; branch_taken = 0;
    tick(1'b0);
    do_reset();
    chk_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0);

    // Load-use on rs
    ex_memread = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
    #1 chk_ctl("lu_rs", 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1);
    chk("lu_rs.stall", {27'd0, stall_cycles}, exp_sc);
    ex_memread = 0;
    #1 chk_ctl("lu_clear", 1'b1, 1'b1, 1'b0, 1'b0);
    // $zero destination never stalls
    ex_memread = 1; ex_rt = 0; id_rs = 0;
    #1 chk_ctl("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0);
    // rt match only counts when rt is read
    ex_rt = 9; id_rt = 9; id_uses_rs = 0; id_uses_rt = 1;
    #1 chk_ctl("lu_rt", 1'b0, 1'b1, 1'b1, 1'b0);
    id_uses_rt = 0;
    #1 chk_ctl("lu_rt_unused", 1'b1, 1'b1, 1'b0, 1'b0);
    ex_memread = 0;

    // Branch with load-use: stall wins, flush follows once hazard is gone
    ex_memread = 1; id_uses_rt = 1; branch_taken = 1;
    #1 chk_ctl("br_lu", 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1);
    ex_memread = 0;
    #1 chk_ctl("br_go", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b0);
    branch_taken = 0; id_uses_rt = 0;
    chk("br.stall", {27'd0, stall_cycles}, exp_sc);

    // MULT
    do_reset();
    ex_md_start = 1; ex_md_is_div = 0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("mul%0d.PCwrite", c), {31'd0, PCwrite}, {31'd0, c == 4});
      chk($sformatf("mul%0d.IDEXwrite", c), {31'd0, IDEXwrite}, {31'd0, c == 4});
      chk($sformatf("mul%0d.busy", c), {31'd0, md_busy}, {31'd0, c >= 2});
      chk($sformatf("mul%0d.done", c), {31'd0, md_done}, {31'd0, c == 4});
      tick(c != 4);
    end
    ex_md_start = 0;
    #1;
    chk("mul.stall", {27'd0, stall_cycles}, 32'd3);
    chk("mul.after_busy", {31'd0, md_busy}, 32'd0);
    chk("mul.after_done", {31'd0, md_done}, 32'd0);

    // DIV, with is_div dropped and hazards/branches thrown at BUSY
    do_reset();
    ex_md_start = 1; ex_md_is_div = 1;
    for (int c = 1; c <= 32; c++) begin
      if (c == 2) ex_md_is_div = 0;
      if (c >= 5 && c <= 10) begin
        ex_memread = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1; branch_taken = 1;
      end else begin
        ex_memread = 0; branch_taken = 0;
      end
      #1;
      chk($sformatf("div%0d.PCwrite", c), {31'd0, PCwrite}, {31'd0, c == 32});
      chk($sformatf("div%0d.busy", c), {31'd0, md_busy}, {31'd0, c >= 2});
      chk($sformatf("div%0d.done", c), {31'd0, md_done}, {31'd0, c == 32});
      if (c >= 5 && c <= 10) begin
        chk($sformatf("div%0d.bubble", c), {31'd0, IDEX_bubble}, 32'd0);
        chk($sformatf("div%0d.flush", c), {31'd0, IFID_flush}, 32'd0);
      end
      tick(c != 32);
    end
    ex_md_start = 0;
    #1;
    chk("div.stall", {27'd0, stall_cycles}, 32'd31);
    // Saturation: another stall must not wrap the counter
    ex_memread = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
    #1 chk_ctl("sat_lu", 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1);
    ex_memread = 0;
    chk("sat.stall", {27'd0, stall_cycles}, exp_sc);

    // Reset mid-DIV at cnt=10 (cycle 22)
    do_reset();
    ex_md_start = 1; ex_md_is_div = 1;
    for (int c = 1; c <= 21; c++) tick(1'b1);
    #1 chk("rst_mid.busy_before", {31'd0, md_busy}, 32'd1);
    rst = 1; ex_md_start = 0;
    #1;
    chk_ctl("rst_mid", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_mid.busy", {31'd0, md_busy}, 32'd0);
    chk("rst_mid.stall", {27'd0, stall_cycles}, 32'd0);
    tick(1'b0);
    rst = 0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      chk($sformatf("post%0d.PCwrite", c), {31'd0, PCwrite}, 32'd1);
      chk($sformatf("post%0d.busy", c), {31'd0, md_busy}, 32'd0);
      chk($sformatf("post%0d.done", c), {31'd0, md_done}, 32'd0);
      tick(1'b0);
    end
    chk("post.stall", {27'd0, stall_cycles}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
